// File: rtl/exec_pkg.sv
// Shared definitions for the execute-side dispatch/arbitration blocks.
// Holds unit count, datapath widths, per-unit FIFO depth, the ROB tag width
// and the packed micro-op record that travels through each unit FIFO.
package exec_pkg;

    localparam int NUM_UNITS       = 4;
    localparam int DATA_W          = 64;
    localparam int CMD_W           = 10;
    localparam int FLAG_W          = 4;
    localparam int UNIT_FIFO_DEPTH = 2;
    localparam int ROB_SIZE        = 8;
    localparam int TAG_W           = $clog2(ROB_SIZE + 1);
    localparam int CNT_W           = $clog2(UNIT_FIFO_DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [CMD_W-1:0]  commands;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
    } exec_uop_t;

endpackage

// File: rtl/execute_dispatch_if.sv
// Bundle of the issue-side input stream and the four per-unit output streams
// of execute_dispatch.
//   slave  : the dispatcher (consumes issue stream, produces unit heads)
//   master : the environment (issue stage + execution units)
interface execute_dispatch_if;
    import exec_pkg::*;

    // issue side
    logic                                 valid_i;
    logic                                 ready_o;
    logic [1:0]                           unitSel_i;
    logic [TAG_W-1:0]                     tag_i;
    logic [CMD_W-1:0]                     commands_i;
    logic [DATA_W-1:0]                    opA_i;
    logic [DATA_W-1:0]                    opB_i;
    logic                                 flush_i;
    // unit side
    logic [NUM_UNITS-1:0]                 valid_o;
    logic [NUM_UNITS-1:0]                 unitReady_i;
    logic [NUM_UNITS-1:0][TAG_W-1:0]      tag_o;
    logic [NUM_UNITS-1:0][CMD_W-1:0]      commands_o;
    logic [NUM_UNITS-1:0][DATA_W-1:0]     opA_o;
    logic [NUM_UNITS-1:0][DATA_W-1:0]     opB_o;
    logic [NUM_UNITS-1:0][CNT_W-1:0]      pending_o;

    modport slave (
        input  valid_i, unitSel_i, tag_i, commands_i, opA_i, opB_i, flush_i, unitReady_i,
        output ready_o, valid_o, tag_o, commands_o, opA_o, opB_o, pending_o
    );

    modport master (
        output valid_i, unitSel_i, tag_i, commands_i, opA_i, opB_i, flush_i, unitReady_i,
        input  ready_o, valid_o, tag_o, commands_o, opA_o, opB_o, pending_o
    );

endinterface

// File: rtl/exec_unit_fifo.sv
// Two-entry FIFO of exec_uop_t in front of one execution unit.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-low reset
//   enq_i, enq_uop_i  write strobe and entry (ignored when full or flushing)
//   deq_i           consume head (ignored when empty or flushing)
//   flush_i         drop all entries on the next edge
//   count_o         occupancy 0..2
//   valid_o, head_o head entry; head_o is zero when empty
//   full_o          occupancy at depth
module exec_unit_fifo
    import exec_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enq_i,
    input  exec_uop_t        enq_uop_i,
    input  logic             deq_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output logic             valid_o,
    output exec_uop_t        head_o,
    output logic             full_o
);

    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    exec_uop_t        mem_q [UNIT_FIFO_DEPTH];
    exec_uop_t        mem_d [UNIT_FIFO_DEPTH];

    logic enq_ok;
    logic deq_ok;

    assign full_o  = (count_q == CNT_W'(UNIT_FIFO_DEPTH));
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    // A full FIFO rejects even while its head is being consumed: no bypass.
    assign enq_ok = enq_i & ~full_o & ~flush_i;
    assign deq_ok = deq_i & valid_o & ~flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (enq_ok) begin
                mem_d[wr_ptr_q] = enq_uop_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (deq_ok) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + CNT_W'(enq_ok) - CNT_W'(deq_ok);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only the control state decides what is visible.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/execute_dispatch.sv
// Fans one issued micro-op stream out to four execution units, each behind
// its own 2-entry FIFO so a stalled unit does not block issue to the others.
// Ports:
//   clk_i    clock
//   reset_i  asynchronous active-low reset
//   io       execute_dispatch_if.slave: issue stream in, per-unit heads out,
//            per-unit consume strobes, flush, per-unit occupancy
module execute_dispatch
    import exec_pkg::*;
#(
    parameter int ROBsize    = 8,
    parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    execute_dispatch_if.slave  io
);

    // The micro-op record carries a package-fixed tag width.
    if (ROBsizeLog != TAG_W) begin : g_bad_tag_w
        $error("execute_dispatch: ROBsizeLog must equal exec_pkg::TAG_W");
    end

    logic [NUM_UNITS-1:0] full;
    logic [NUM_UNITS-1:0] vld;
    logic [NUM_UNITS-1:0] enq;
    logic [CNT_W-1:0]     cnt  [NUM_UNITS];
    exec_uop_t            head [NUM_UNITS];
    exec_uop_t            in_uop;
    logic                 ready;
    logic                 accept;

    // Gated by reset_i so the issue stage sees "not ready" while in reset.
    assign ready      = reset_i & ~full[io.unitSel_i] & ~io.flush_i;
    assign io.ready_o = ready;
    assign accept     = io.valid_i & ready;

    assign in_uop.tag      = io.tag_i;
    assign in_uop.commands = io.commands_i;
    assign in_uop.op_a     = io.opA_i;
    assign in_uop.op_b     = io.opB_i;

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        assign enq[u] = accept & (io.unitSel_i == 2'(u));

        exec_unit_fifo u_fifo (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .enq_i     (enq[u]),
            .enq_uop_i (in_uop),
            .deq_i     (io.unitReady_i[u]),
            .flush_i   (io.flush_i),
            .count_o   (cnt[u]),
            .valid_o   (vld[u]),
            .head_o    (head[u]),
            .full_o    (full[u])
        );
    end

    always_comb begin
        io.valid_o = vld;
        for (int u = 0; u < NUM_UNITS; u++) begin
            io.tag_o[u]      = head[u].tag;
            io.commands_o[u] = head[u].commands;
            io.opA_o[u]      = head[u].op_a;
            io.opB_o[u]      = head[u].op_b;
            io.pending_o[u]  = cnt[u];
        end
    end

endmodule

// File: doc/execute_dispatch.md
# execute_dispatch

Issue-side distributor for the four execution units. It accepts one issued micro-op per cycle from the issue/reservation stage and routes it to the execution unit named by `unitSel_i`. Each unit has a 2-entry FIFO, so a stalled unit does not block issue to the others. It is the mirror of the execute-output arbiter: that block merges four unit results into one stream, this block fans one stream out to four units.

## Interface
Parameters:
- `ROBsize`, 8, number of ROB entries.
- `ROBsizeLog`, `$clog2(ROBsize+1)`, tag width.

Ports:
- `clk_i`  in  1  clock, single domain.
- `reset_i`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  issue micro-op valid.
- `ready_o`  out  1  selected unit can accept.
- `unitSel_i`  in  2  destination execution unit, 0..3.
- `tag_i`  in  ROBsizeLog  ROB tag.
- `commands_i`  in  10  decoded command bits.
- `opA_i`, `opB_i`  in  64 each  source operands.
- `flush_i`  in  1  squash all buffered micro-ops.
- `valid_o`  out  [3:0]  per-unit head valid.
- `unitReady_i`  in  [3:0]  per-unit consume.
- `tag_o`  out  [3:0][ROBsizeLog-1:0]  per-unit head tag.
- `commands_o`  out  [3:0][9:0]  per-unit head command.
- `opA_o`, `opB_o`  out  [3:0][63:0]  per-unit head operands.
- `pending_o`  out  [3:0][1:0]  per-unit occupancy, 0..2.

## Operation
- Enqueue when `valid_i & ready_o`. The entry goes to FIFO `unitSel_i`. No other FIFO changes.
- `ready_o = ~full[unitSel_i] & ~flush_i`.
  - `ready_o` is combinational only on `unitSel_i`, registered occupancy and `flush_i`.
  - It never depends on `unitReady_i`. There is no bypass: a full FIFO rejects even when it is dequeuing that cycle.
- Dequeue unit u when `valid_o[u] & unitReady_i[u]`.
- `valid_o[u] = (count[u] != 0)`. Head fields come from the read-pointer entry.
  - When `valid_o[u] = 0`, all four head fields of unit u drive 0.
- Simultaneous enqueue and dequeue on the same FIFO (count 1): the count stays 1, write and read pointers both advance, order is preserved.
- Per-FIFO state is a 1-bit read pointer, a 1-bit write pointer and a 2-bit count.
  - Pointers wrap 1→0.
  - The count never exceeds 2.
- `pending_o[u] = count[u]`.
- `flush_i`, synchronous, takes priority over enqueue and dequeue. All counts and pointers go to 0 on the next edge. `ready_o` is low while `flush_i` is high.
- A `unitSel_i` value is always in range (2 bits); no error case exists.
- Asynchronous reset (`reset_i = 0`), including mid-operation:
  - All counts and pointers go to 0 immediately.
  - `valid_o = 0`, `pending_o = 0`, head fields = 0.
  - `ready_o = 0` while reset is asserted and 1 after release (all FIFOs empty, no flush).
  - Storage contents are don't-care.

## Timing
- Latency: a micro-op accepted at edge N appears on `valid_o[u]` after edge N (cycle N+1) if its FIFO was empty.
- Throughput is one enqueue per cycle total and one dequeue per unit per cycle; four dequeues may happen in one cycle.
- `valid_o[u]` stays high with stable head fields until `unitReady_i[u]` is sampled high.
- `pending_o` and `valid_o` are registered-state derived, with no combinational path from `valid_i`.

## Structure
- Shared package `exec_pkg` holds:
  - `NUM_UNITS = 4`, `DATA_W = 64`, `CMD_W = 10`, `FLAG_W = 4`, `UNIT_FIFO_DEPTH = 2`;
  - typedef `exec_uop_t` packing tag, commands, opA and opB. The tag width comes from a package parameter matching `ROBsizeLog`.
- Sub-module `exec_unit_fifo`: a 2-entry FIFO of `exec_uop_t` with enq, deq, flush, count, head and full. `execute_dispatch` instantiates it four times with a generate loop and decodes `unitSel_i` into the per-FIFO enqueue strobes.

## Test plan
- Reset then single issue: `unitSel_i = 2`, `tag_i = 5`, `opA_i = 0x10`.
  - Required: `valid_o = 4'b0100` next cycle, `tag_o[2] = 5`, `pending_o[2] = 1`.
  - With `unitReady_i[2] = 1`, `valid_o[2]` drops the following cycle.
- Fill: three issues to unit 1 with `unitReady_i = 0`.
  - Required: first two accepted, `ready_o = 0` on the third, `pending_o[1] = 2`.
  - Issue to unit 3 in the same stalled state is accepted.
- Order and wrap: stream tags 1..6 to unit 0 with `unitReady_i[0]` toggling every cycle.
  - Required: the tags are dequeued in order 1..6, with no loss or duplication.
- Simultaneous enqueue and dequeue at count 1 on unit 0: count stays 1 and the head advances to the newer tag.
  - At count 2 with `unitReady_i[0] = 1`, issue to unit 0 is rejected.
- Flush: load units 0–3 with one entry each, assert `flush_i` together with `valid_i`.
  - Required: `ready_o = 0`, and all `valid_o` and `pending_o` are 0 the next cycle.
- Async reset mid-stream: drop `reset_i` between edges with entries buffered.
  - Required: outputs clear immediately, without waiting for a clock edge.
  - After release, a fresh issue behaves as in the first scenario.
